// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start/op/a/b request, flush cancel, busy/done/result response.
module seq_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state;
    state_t state_nx;

    // Operation attributes kept for the sign fix-up at the end
    logic rem_op;
    logic neg_q;
    logic neg_r;

    // Datapath registers
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  dsr;
    logic [XLEN-1:0]  rem;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  res_q;
    logic [XLEN-1:0]  result_r;

    // Request decode
    logic            is_rem;
    logic            is_uns;
    logic            accept;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    assign is_rem   = op[1];
    assign is_uns   = op[0];
    assign accept   = (state == IDLE) && start && !flush;
    assign div_zero = (b == '0);
    assign ovf      = !is_uns && (a == MIN_NEG) && (b == '1);
    assign special  = div_zero || ovf;
    assign a_neg    = !is_uns && a[XLEN-1];
    assign b_neg    = !is_uns && b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;

    always_comb begin
        special_val = '0;
        unique case (1'b1)
            div_zero: special_val = is_rem ? a : '1;
            ovf:      special_val = is_rem ? '0 : MIN_NEG;
            default:  special_val = '0;
        endcase
    end

    // One restoring step: shift in the next dividend bit, try to subtract.
    // The top remainder bit is always zero before a step, so dropping it is safe.
    logic [XLEN-1:0] shifted;
    logic [XLEN:0]   trial;
    logic            qbit;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] dvd_nx;
    logic            last;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;
    logic [XLEN-1:0] fin_val;

    assign shifted = {rem[XLEN-2:0], dvd[XLEN-1]};
    assign trial   = {1'b0, shifted} - {1'b0, dsr};
    assign qbit    = ~trial[XLEN];
    assign rem_nx  = qbit ? trial[XLEN-1:0] : shifted;
    assign dvd_nx  = {dvd[XLEN-2:0], qbit};
    assign last    = (cnt == CNT_W'(1));
    assign fin_q   = neg_q ? -dvd_nx : dvd_nx;
    assign fin_r   = neg_r ? -rem_nx : rem_nx;
    assign fin_val = rem_op ? fin_r : fin_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = special ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy     = 1'b1;
                done     = !flush;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_op   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_op <= is_rem;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (special) begin
                            res_q <= special_val;
                        end else begin
                            dvd <= a_mag;
                            dsr <= b_mag;
                            rem <= '0;
                            cnt <= CNT_W'(XLEN);
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                        cnt <= cnt - CNT_W'(1);
                        if (last) begin
                            res_q <= fin_val;
                        end
                    end
                end
                FIN: begin
                    // A flushed FIN leaves the previously committed result
                    if (!flush) begin
                        result_r <= res_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // The new value is visible during FIN itself, then held in result_r
    assign result = (state == FIN && !flush) ? res_q : result_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV32M cases, handshake corners, random ops.
// Reference results come from plain integer division with the RISC-V special cases.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_divider #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'h0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
        sx = x;
        sy = y;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one operation; glitch>0 pulses a foreign start in that busy cycle
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int glitch);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        bit busy_ok;
        exp = model(o, x, y);
        exp_lat = is_special(o, x, y) ? 1 : 33;
        lat = 0;
        busy_ok = 1'b1;
        launch(o, x, y);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (n == glitch) begin
                op = 2'b01;
                a = $urandom;
                b = $urandom_range(1, 9);
                start = 1'b1;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        bit seen;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int mode;

        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        run("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        check("div -7/2 value", result, 32'hFFFF_FFFD);
        run("rem -7%2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        check("rem -7%2 value", result, 32'hFFFF_FFFF);
        run("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        run("remu 100%7", 2'b11, 32'd100, 32'd7, 0);
        check("remu 100%7 value", result, 32'd2);
        run("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
        run("div by 0", 2'b00, 32'd5, 32'd0, 0);
        run("remu by 0", 2'b11, 32'd5, 32'd0, 0);
        run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Foreign start while busy, then back-to-back accept after FIN
        run("divu glitch", 2'b01, 32'd1000, 32'd3, 10);
        check("divu glitch value", result, 32'd333);
        run("back2back", 2'b10, 32'd1000, 32'd3, 0);

        // Start presented during FIN must be ignored
        launch(2'b00, 32'd5, 32'd0);
        @(negedge clk);
        check("fin done", 32'(done), 32'd1);
        op = 2'b01;
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin start busy", 32'(busy), 32'd0);
        check("fin start done", 32'(done), 32'd0);
        check("fin start result", result, 32'hFFFF_FFFF);

        // Flush wins over start in IDLE
        @(negedge clk);
        op = 2'b01;
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle flush busy", 32'(busy), 32'd0);

        // Flush mid-CALC
        run("pre flush", 2'b00, 32'd100, 32'd7, 0);
        launch(2'b00, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, 32'd14);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush no done", 32'(seen), 32'd0);

        // Reset mid-operation
        launch(2'b01, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: ry = 32'd0;
                1: begin
                    rx = 32'h8000_0000;
                    ry = 32'hFFFF_FFFF;
                end
                2: ry = $urandom_range(1, 15);
                3: ry = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: ry = $urandom;
            endcase
            run($sformatf("rnd%0d op%0d", i, ro), ro, rx, ry, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
